// File: rtl/debug_addr_seq.sv
// debug_addr_seq: strided debug address sweep over a latched range with WRAP, ONESHOT and PINGPONG modes.
module debug_addr_seq #(
  parameter int LENGTH = 12000,
  parameter int WIDTH  = $clog2(LENGTH),
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  cfg_base,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic [1:0]        cfg_mode,
  input  logic              addr_ready,
  output logic [WIDTH-1:0]  debug_addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pass_cnt
);
  localparam int AW = WIDTH + 1;
  localparam logic [1:0] M_WRAP = 2'b00;
  localparam logic [1:0] M_ONE  = 2'b01;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q;
  logic [WIDTH-1:0]  addr_q, base_q, limit_q, addr_d;
  logic [STEP_W-1:0] step_q;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  pass_q, pass_d, pass_inc;
  logic              dir_q, dir_d, err_q, fin, up_ok, dn_ok, cfg_bad;
  logic [AW-1:0]     step_x, up_sum;
  logic [WIDTH-1:0]  dn_addr;
  // Range checks are done one bit wider so neither cur+step nor base+step can wrap.
  assign step_x   = AW'(step_q);
  assign up_sum   = {1'b0, addr_q} + step_x;
  assign dn_addr  = addr_q - WIDTH'(step_q);
  assign up_ok    = up_sum <= {1'b0, limit_q};
  assign dn_ok    = {1'b0, addr_q} >= ({1'b0, base_q} + step_x);
  assign pass_inc = (&pass_q) ? pass_q : pass_q + 1'b1;
  assign cfg_bad  = (cfg_base > cfg_limit) | (32'(cfg_limit) >= LENGTH) | (cfg_step == '0) | (cfg_mode == 2'b11);
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    pass_d = pass_q;
    fin    = 1'b0;
    if (!dir_q) begin
      if (up_ok) addr_d = up_sum[WIDTH-1:0];
      else if (mode_q == M_WRAP) begin
        addr_d = base_q;
        pass_d = pass_inc;
      end else if (mode_q == M_ONE) fin = 1'b1;
      else begin
        dir_d  = 1'b1;
        addr_d = dn_ok ? dn_addr : addr_q;
      end
    end else if (dn_ok) addr_d = dn_addr;
    else begin
      dir_d  = 1'b0;
      pass_d = pass_inc;
      addr_d = up_ok ? up_sum[WIDTH-1:0] : addr_q;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      mode_q  <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (cfg_bad) err_q <= 1'b1;
          else begin
            state_q <= RUN;
            base_q  <= cfg_base;
            limit_q <= cfg_limit;
            step_q  <= cfg_step;
            mode_q  <= cfg_mode;
            addr_q  <= cfg_base;
            dir_q   <= 1'b0;
            pass_q  <= '0;
          end
        end
        RUN: if (stop) state_q <= IDLE;
        else if (addr_ready) begin
          addr_q  <= addr_d;
          dir_q   <= dir_d;
          pass_q  <= fin ? CNT_W'(1) : pass_d;
          state_q <= fin ? DONE : RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign debug_addr = addr_q;
  assign addr_valid = state_q == RUN;
  assign busy       = state_q == RUN;
  assign done       = state_q == DONE;
  assign cfg_err    = err_q;
  assign pass_cnt   = pass_q;
endmodule

// File: doc/debug_addr_seq.md
DEBUG_ADDR_SEQ -- requirements
Module: debug_addr_seq

Interface
REQ-001 SHALL have parameter LENGTH, default 12000, number of addressable debug locations (0..LENGTH-1).
REQ-002 SHALL have parameter WIDTH, default $clog2(LENGTH), address width.
REQ-003 SHALL have parameter STEP_W, default 8, stride width; STEP_W <= WIDTH.
REQ-004 SHALL have parameter CNT_W, default 16, pass counter width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rstn.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle pulse; latch config and begin sweep; honoured only in IDLE.
REQ-009 stop  input  1  abort sweep, return to IDLE.
REQ-010 cfg_base, cfg_limit  input  WIDTH each  inclusive sweep range.
REQ-011 cfg_step  input  STEP_W  address stride.
REQ-012 cfg_mode  input  2  00 WRAP, 01 ONESHOT, 10 PINGPONG, 11 reserved.
REQ-013 addr_ready  input  1  consumer accepts debug_addr.
REQ-014 debug_addr  output  WIDTH  current address.
REQ-015 addr_valid  output  1  debug_addr valid.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse at ONESHOT completion.
REQ-018 cfg_err  output  1  one-cycle pulse on rejected start.
REQ-019 pass_cnt  output  CNT_W  completed passes since last accepted start, saturating.

Function
REQ-020 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN); addr_valid = (state==RUN).
REQ-021 IDLE + start: config is invalid if base > limit, limit >= LENGTH, step == 0 or mode == 11; invalid -> cfg_err=1 next cycle, stay IDLE, registers unchanged.
REQ-022 IDLE + valid start: next cycle RUN, debug_addr=base, direction=up, pass_cnt=0; config is latched and later cfg_* changes are ignored until the next start.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 Address advances only on a cycle with addr_valid & addr_ready; with addr_ready low, debug_addr and addr_valid SHALL hold stable.
REQ-025 Next-address arithmetic SHALL use WIDTH+1 bits so cur+step and cur-step never wrap silently.
REQ-026 Up direction: if cur+step <= limit, next = cur+step; otherwise end-of-pass at top.
REQ-027 WRAP end-of-pass: next = base, pass_cnt += 1.
REQ-028 ONESHOT end-of-pass: transition to DONE; pass_cnt = 1; debug_addr holds last address.
REQ-029 PINGPONG top end-of-pass: direction = down; next = cur-step if >= base, else cur.
REQ-030 PINGPONG down direction: if cur-step >= base, next = cur-step; otherwise direction = up, pass_cnt += 1, and next = cur+step if <= limit, else cur.
REQ-031 PINGPONG with base == limit SHALL hold debug_addr at base, incrementing pass_cnt every two accepted transfers.
REQ-032 DONE SHALL last exactly one cycle with done=1 and addr_valid=0, then go to IDLE.
REQ-033 stop in RUN: next cycle IDLE, addr_valid=0, done not asserted, pass_cnt held; a handshake in the same cycle counts as accepted but causes no further address.
REQ-034 stop in IDLE or DONE SHALL have no effect.
REQ-035 pass_cnt SHALL saturate at 2^CNT_W-1.
REQ-036 In IDLE, debug_addr and pass_cnt SHALL hold their last values.

Reset
REQ-037 rstn low SHALL immediately force state=IDLE, debug_addr=0, addr_valid=0, busy=0, done=0, cfg_err=0, pass_cnt=0, direction=up, and clear the latched config; this applies at any time, including mid-sweep.
REQ-038 The first start after rstn rises SHALL be honoured.

Verification
REQ-039 WRAP, base=2, limit=6, step=2, ready=1 -> addresses 2,4,6,2,4,6…; pass_cnt increments on each return to 2.
REQ-040 ONESHOT, base=0, limit=9, step=3, ready toggling -> addresses 0,3,6,9, each held while ready=0; done pulses one cycle after 9 is accepted; then IDLE.
REQ-041 PINGPONG, base=0, limit=4, step=1 -> addresses 0,1,2,3,4,3,2,1,0,1…; pass_cnt=1 after the return to 0 and the up-turn.
REQ-042 start with base=8, limit=3 (and separately limit=LENGTH or mode=11) -> cfg_err one-cycle pulse, busy stays 0.
REQ-043 stop asserted mid-WRAP while ready=0 -> next cycle addr_valid=0, busy=0, done=0; a second start re-runs from base with pass_cnt=0.
REQ-044 rstn pulsed low mid-RUN at debug_addr=5 -> all outputs zero asynchronously; after release, the block stays idle until start.
